// File: rtl/mult_pkg.sv
// ============================================================================
// Module      : mult_pkg
// Description : Shared types and constants for the iterative Booth multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Booth pair {Q[0], q-1}; 00 and 11 leave the accumulator unchanged.
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_step.sv
// ============================================================================
// Module      : booth_step
// Description : One combinational radix-2 Booth step (add/sub, then shift).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH+1:0] acc_i,
    input  logic [WIDTH:0]   q_i,
    input  logic             qm1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH+1:0] acc_o,
    output logic [WIDTH:0]   q_o,
    output logic             qm1_o
);

    logic [WIDTH+1:0] w_m_ext;
    logic [WIDTH+1:0] w_sum;

    always_comb begin
        w_m_ext = {m_i[WIDTH], m_i};
        case ({q_i[0], qm1_i})
            BOOTH_ADD: w_sum = acc_i + w_m_ext;
            BOOTH_SUB: w_sum = acc_i - w_m_ext;
            default:   w_sum = acc_i;
        endcase
    end

    // Arithmetic right shift of the concatenation {A, Q, q-1}.
    assign acc_o = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
    assign q_o   = {w_sum[0], q_i[WIDTH:1]};
    assign qm1_o = q_i[0];

endmodule

`default_nettype wire

// File: rtl/booth_mult_iter.sv
// ============================================================================
// Module      : booth_mult_iter
// Description : Iterative radix-2 Booth multiplier, signed/unsigned, flushable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mult_iter
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic               flush,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] z,
    output logic               busy,
    output logic               done
);

    localparam int             CW        = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q,   cnt_d;
    logic [WIDTH:0]       m_q,     m_d;
    logic [WIDTH:0]       q_q,     q_d;
    logic                 qm1_q,   qm1_d;
    logic [WIDTH+1:0]     acc_q,   acc_d;
    logic [2*WIDTH-1:0]   z_q,     z_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;

    logic [WIDTH+1:0]     w_acc_nxt;
    logic [WIDTH:0]       w_q_nxt;
    logic                 w_qm1_nxt;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i (acc_q),
        .q_i   (q_q),
        .qm1_i (qm1_q),
        .m_i   (m_q),
        .acc_o (w_acc_nxt),
        .q_o   (w_q_nxt),
        .qm1_o (w_qm1_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            acc_q   <= '0;
            z_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        acc_d   = acc_q;
        z_d     = z_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        // Flush takes priority over start so a squashed issue never begins.
        if (flush) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else if (start) begin
            state_d = RUN;
            busy_d  = 1'b1;
            cnt_d   = '0;
            acc_d   = '0;
            qm1_d   = 1'b0;
            m_d     = is_signed ? {a[WIDTH-1], a} : {1'b0, a};
            q_d     = is_signed ? {b[WIDTH-1], b} : {1'b0, b};
        end else if (state_q == RUN) begin
            acc_d = w_acc_nxt;
            q_d   = w_q_nxt;
            qm1_d = w_qm1_nxt;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_STEP) begin
                z_d     = {w_acc_nxt[WIDTH-2:0], w_q_nxt};
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        end
    end

    assign z    = z_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

`default_nettype wire
